mont_exp_seq: RTL and testbench

Left-to-right square-and-multiply sequencer for modular exponentiation over a shared Montgomery multiplier. It converts the base into the Montgomery domain, walks the exponent MSB-first issuing square and multiply operations, then converts the result back. It sits between the host-facing RSA wrapper and one Montgomery multiplier instance, which it drives through a start/done handshake.

---
 rtl/mont_pkg.sv | 25 ++
 rtl/mont_msb_find.sv | 24 ++
 rtl/mont_exp_seq.sv | 156 +++++++++++++++
 tb/tb_mont_exp_seq.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mont_pkg.sv
// Shared types for the Montgomery exponentiation sequencer.
// Holds the sequencer state enum, default widths and the op-code enum
// used when tracing multiplier operations.
package mont_pkg;

    localparam int unsigned W_DEF     = 256;
    localparam int unsigned EXP_W_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TOMONT,
        ST_SQR,
        ST_MUL,
        ST_FROMMONT,
        ST_FIN
    } state_t;

    typedef enum logic [1:0] {
        OP_TOMONT,
        OP_SQR,
        OP_MUL,
        OP_FROMMONT
    } op_t;

endpackage

// File: rtl/mont_msb_find.sv
// Priority encoder: index of the highest set bit of value, plus a zero flag.
// Used only when MONT_EXP_LZ_SKIP_EN is defined.
module mont_msb_find #(
    parameter int unsigned EXP_W = 32,
    parameter int unsigned IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1
) (
    input  logic [EXP_W-1:0] value,
    output logic [IDX_W-1:0] idx,
    output logic             zero
);

    // Scan upward so the last set bit seen (the highest) wins.
    always_comb begin
        idx  = '0;
        zero = 1'b1;
        for (int unsigned k = 0; k < EXP_W; k++) begin
            if (value[k]) begin
                idx  = IDX_W'(k);
                zero = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mont_exp_seq.sv
// Left-to-right square-and-multiply sequencer driving one Montgomery
// multiplier through a start/done handshake.
// Optional feature: MONT_EXP_LZ_SKIP_EN skips the leading-zero squares of
// the exponent (and the whole loop for exponent == 0).
module mont_exp_seq
    import mont_pkg::*;
#(
    parameter int unsigned W     = W_DEF,
    parameter int unsigned EXP_W = EXP_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     base,
    input  logic [EXP_W-1:0] exponent,
    input  logic [W-1:0]     r2,
    input  logic [W-1:0]     rmodn,
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     result,
    output logic             mm_start,
    output logic [W-1:0]     mm_a,
    output logic [W-1:0]     mm_b,
    input  logic             mm_done,
    input  logic [W-1:0]     mm_res
);

    localparam int unsigned IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

    state_t           state;
    logic [EXP_W-1:0] exp_q;
    logic [W-1:0]     acc;
    logic [W-1:0]     base_m;
    logic [IDX_W-1:0] idx;
    logic             wait_done;
    logic             last_bit;

`ifdef MONT_EXP_LZ_SKIP_EN
    logic [IDX_W-1:0] lz_idx;
    logic             lz_zero;
    logic             exp_zero;

    mont_msb_find #(
        .EXP_W (EXP_W),
        .IDX_W (IDX_W)
    ) u_msb_find (
        .value (exponent),
        .idx   (lz_idx),
        .zero  (lz_zero)
    );
`endif

    // A completion only counts once the issue pulse has dropped.
    always_comb begin
        wait_done = mm_done && !mm_start;
        last_bit  = (idx == '0);
    end

    // Sequencer FSM with registered handshake, operand and status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            mm_start <= 1'b0;
            mm_a     <= '0;
            mm_b     <= '0;
            result   <= '0;
            exp_q    <= '0;
            acc      <= '0;
            base_m   <= '0;
            idx      <= '0;
`ifdef MONT_EXP_LZ_SKIP_EN
            exp_zero <= 1'b0;
`endif
        end else begin
            mm_start <= 1'b0;
            done     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        exp_q    <= exponent;
                        acc      <= rmodn;
`ifdef MONT_EXP_LZ_SKIP_EN
                        idx      <= lz_idx;
                        exp_zero <= lz_zero;
`else
                        idx      <= IDX_W'(EXP_W - 1);
`endif
                        busy     <= 1'b1;
                        mm_start <= 1'b1;
                        mm_a     <= base;
                        mm_b     <= r2;
                        state    <= ST_TOMONT;
                    end
                end
                ST_TOMONT: begin
                    if (wait_done) begin
                        base_m   <= mm_res;
                        mm_start <= 1'b1;
`ifdef MONT_EXP_LZ_SKIP_EN
                        if (exp_zero) begin
                            mm_a  <= acc;
                            mm_b  <= W'(1);
                            state <= ST_FROMMONT;
                        end else begin
                            mm_a  <= acc;
                            mm_b  <= acc;
                            state <= ST_SQR;
                        end
`else
                        mm_a     <= acc;
                        mm_b     <= acc;
                        state    <= ST_SQR;
`endif
                    end
                end
                // SQR and MUL forward mm_res straight into the next operands,
                // since acc only takes that value at this same edge.
                ST_SQR, ST_MUL: begin
                    if (wait_done) begin
                        acc      <= mm_res;
                        mm_start <= 1'b1;
                        if (state == ST_SQR && exp_q[idx]) begin
                            mm_a  <= mm_res;
                            mm_b  <= base_m;
                            state <= ST_MUL;
                        end else if (last_bit) begin
                            mm_a  <= mm_res;
                            mm_b  <= W'(1);
                            state <= ST_FROMMONT;
                        end else begin
                            idx   <= idx - IDX_W'(1);
                            mm_a  <= mm_res;
                            mm_b  <= mm_res;
                            state <= ST_SQR;
                        end
                    end
                end
                ST_FROMMONT: begin
                    if (wait_done) begin
                        result <= mm_res;
                        done   <= 1'b1;
                        state  <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mont_exp_seq.sv
// Bench for mont_exp_seq: W=8, EXP_W=8, N=13, R mod N=9, R^2 mod N=3.
// A behavioural Montgomery multiplier answers each request after a
// configurable latency; results are checked against plain modular powers.
module tb_mont_exp_seq;

    localparam int unsigned W     = 8;
    localparam int unsigned EXP_W = 8;
    localparam int unsigned N     = 13;
    localparam int unsigned RMODN = 9;
    localparam int unsigned R2    = 3;
    localparam int unsigned RINV  = 3;   // 256^-1 mod 13

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [W-1:0]     base;
    logic [EXP_W-1:0] exponent;
    logic [W-1:0]     r2;
    logic [W-1:0]     rmodn;
    logic             busy;
    logic             done;
    logic [W-1:0]     result;
    logic             mm_start;
    logic [W-1:0]     mm_a;
    logic [W-1:0]     mm_b;
    logic             mm_done;
    logic [W-1:0]     mm_res;

    mont_exp_seq #(
        .W     (W),
        .EXP_W (EXP_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base     (base),
        .exponent (exponent),
        .r2       (r2),
        .rmodn    (rmodn),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .mm_start (mm_start),
        .mm_a     (mm_a),
        .mm_b     (mm_b),
        .mm_done  (mm_done),
        .mm_res   (mm_res)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Multiplier model state
    int         cnt        = 0;
    int         lat_min    = 3;
    int         lat_max    = 3;
    int         op_count   = 0;
    bit         chk_stable = 1'b1;
    logic [W-1:0] cap_a, cap_b;
    logic [W-1:0] ops_a[$];
    logic [W-1:0] ops_b[$];

    function automatic logic [W-1:0] mont_mul(input int unsigned a, input int unsigned b);
        return W'((a * b * RINV) % N);
    endfunction

    function automatic logic [W-1:0] pow_mod(input int unsigned b, input int unsigned e);
        int unsigned r = 1;
        for (int unsigned k = 0; k < e; k++) r = (r * b) % N;
        return W'(r % N);
    endfunction

    function automatic int msb_of(input logic [EXP_W-1:0] e);
        int m = -1;
        for (int k = 0; k < int'(EXP_W); k++) if (e[k]) m = k;
        return m;
    endfunction

    function automatic int expected_ops(input logic [EXP_W-1:0] e);
`ifdef MONT_EXP_LZ_SKIP_EN
        if (e == '0) return 2;
        return 2 + msb_of(e) + 1 + $countones(e);
`else
        return 2 + int'(EXP_W) + $countones(e);
`endif
    endfunction

    // Behavioural multiplier: captures operands on mm_start, answers after latency.
    initial begin
        mm_done = 1'b0;
        mm_res  = '0;
        forever begin
            @(negedge clk);
            mm_done = 1'b0;
            if (cnt > 0) begin
                if (chk_stable) begin
                    check_val("mm_a_stable", mm_a, cap_a);
                    check_val("mm_b_stable", mm_b, cap_b);
                    check_val("mm_start_pulse", mm_start, 0);
                end
                cnt--;
                if (cnt == 0) begin
                    mm_done = 1'b1;
                    mm_res  = mont_mul(cap_a, cap_b);
                end
            end else if (mm_start) begin
                cap_a = mm_a;
                cap_b = mm_b;
                ops_a.push_back(mm_a);
                ops_b.push_back(mm_b);
                op_count++;
                cnt = $urandom_range(lat_max, lat_min);
            end
        end
    end

    task automatic run_exp(input string name, input logic [W-1:0] b, input logic [EXP_W-1:0] e,
                           input bit poke);
        logic [W-1:0] want;
        logic [W-1:0] ea[$];
        logic [W-1:0] eb[$];
        logic [W-1:0] acc, bm;
        int hi;
        bit seen;
        want = pow_mod(b, e);
        // Expected operand stream from the square-and-multiply rules
        bm = mont_mul(b, R2);
        ea.push_back(b); eb.push_back(W'(R2));
        acc = W'(RMODN);
`ifdef MONT_EXP_LZ_SKIP_EN
        hi = msb_of(e);
`else
        hi = int'(EXP_W) - 1;
`endif
        for (int k = hi; k >= 0; k--) begin
            ea.push_back(acc); eb.push_back(acc);
            acc = mont_mul(acc, acc);
            if (e[k]) begin
                ea.push_back(acc); eb.push_back(bm);
                acc = mont_mul(acc, bm);
            end
        end
        ea.push_back(acc); eb.push_back(W'(1));

        op_count = 0;
        ops_a.delete();
        ops_b.delete();
        @(negedge clk);
        base = b; exponent = e; start = 1'b1;
        @(negedge clk);
        start = 1'b0; base = '0; exponent = '0;
        check_val({name, "_busy_accept"}, busy, 1);
        seen = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (poke && t == 15) begin
                start = 1'b1; base = 8'd5; exponent = 8'h03;
            end else if (poke && t == 16) begin
                start = 1'b0; base = '0; exponent = '0;
            end
            @(negedge clk);
        end
        check_val({name, "_done_seen"}, seen, 1);
        if (seen) begin
            check_val({name, "_result"}, result, want);
            check_val({name, "_busy_at_done"}, busy, 1);
            check_val({name, "_op_count"}, op_count, expected_ops(e));
            if (ops_a.size() == ea.size()) begin
                for (int k = 0; k < ea.size(); k++) begin
                    check_val({name, "_op_a"}, ops_a[k], ea[k]);
                    check_val({name, "_op_b"}, ops_b[k], eb[k]);
                end
            end else begin
                check_val({name, "_op_stream_len"}, ops_a.size(), ea.size());
            end
            @(negedge clk);
            check_val({name, "_done_one_cycle"}, done, 0);
            check_val({name, "_busy_after"}, busy, 0);
            check_val({name, "_result_held"}, result, want);
        end
    endtask

    task automatic reset_mid_run();
        bit reached;
        bit quiet;
        op_count = 0;
        @(negedge clk);
        base = 8'd7; exponent = 8'hAB; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reached = 1'b0;
        for (int t = 0; t < 500; t++) begin
            if (op_count == 4 && cnt > 1) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_val("rst_reach_op4", reached, 1);
        chk_stable = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_mm_start", mm_start, 0);
        rst = 1'b1;
        quiet = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (mm_start || busy || done) quiet = 1'b0;
        end
        check_val("rst_late_done_ignored", quiet, 1);
        check_val("rst_model_idle", cnt, 0);
        chk_stable = 1'b1;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; base = '0; exponent = '0;
        r2 = W'(R2); rmodn = W'(RMODN);
        repeat (3) @(negedge clk);
        check_val("reset_busy", busy, 0);
        check_val("reset_done", done, 0);
        check_val("reset_mm_start", mm_start, 0);
        check_val("reset_result", result, 0);
        check_val("reset_mm_a", mm_a, 0);
        check_val("reset_mm_b", mm_b, 0);
        rst = 1'b1;
        @(negedge clk);

        run_exp("b2e5", 8'd2, 8'd5, 1'b0);
        run_exp("b7e0", 8'd7, 8'd0, 1'b0);
        run_exp("b3eff", 8'd3, 8'hFF, 1'b0);
        run_exp("poke", 8'd2, 8'd5, 1'b1);
        reset_mid_run();
        run_exp("post_rst", 8'd2, 8'd5, 1'b0);

        lat_min = 1;
        lat_max = 10;
        for (int n = 0; n < 200; n++) begin
            run_exp("rand", W'($urandom_range(12, 0)), EXP_W'($urandom), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
